// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - strobe/enable inputs and timing outputs of vga_timing_gen
interface vga_timing_gen_if #(
  parameter int H_CW    = 11,
  parameter int V_CW    = 10,
  parameter int FRAME_W = 8
);
  logic               i_pix_stb;
  logic               i_en;
  logic               o_hs;
  logic               o_vs;
  logic               o_active;
  logic               o_blanking;
  logic [H_CW-1:0]    o_x;
  logic [V_CW-1:0]    o_y;
  logic               o_line_start;
  logic               o_frame_start;
  logic               o_animate;
  logic               o_screenend;
  logic [FRAME_W-1:0] o_frame;

  // timing generator side
  modport master (
    input  i_pix_stb, i_en,
    output o_hs, o_vs, o_active, o_blanking, o_x, o_y,
           o_line_start, o_frame_start, o_animate, o_screenend, o_frame
  );

  // strobe source / renderer side
  modport slave (
    output i_pix_stb, i_en,
    input  o_hs, o_vs, o_active, o_blanking, o_x, o_y,
           o_line_start, o_frame_start, o_animate, o_screenend, o_frame
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator; frame counter under VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int H_CW       = 11,
  parameter int V_CW       = 10,
  parameter int FRAME_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CW-1:0] H_LAST     = H_CW'(H_TOTAL - 1);
  localparam logic [H_CW-1:0] H_ACT_N    = H_CW'(H_ACTIVE);
  localparam logic [H_CW-1:0] H_ACT_LAST = H_CW'(H_ACTIVE - 1);
  localparam logic [H_CW-1:0] H_SYNC_BEG = H_CW'(H_ACTIVE + H_FP);
  localparam logic [H_CW-1:0] H_SYNC_END = H_CW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_CW-1:0] V_LAST     = V_CW'(V_TOTAL - 1);
  localparam logic [V_CW-1:0] V_ACT_N    = V_CW'(V_ACTIVE);
  localparam logic [V_CW-1:0] V_ACT_LAST = V_CW'(V_ACTIVE - 1);
  localparam logic [V_CW-1:0] V_SYNC_BEG = V_CW'(V_ACTIVE + V_FP);
  localparam logic [V_CW-1:0] V_SYNC_END = V_CW'(V_ACTIVE + V_FP + V_SYNC);

  logic            adv;
  logic [H_CW-1:0] h_q, h_d;
  logic [V_CW-1:0] v_q, v_d;

  logic            hs_q, vs_q, active_q, blank_q;
  logic [H_CW-1:0] x_q;
  logic [V_CW-1:0] y_q;
  logic            line_start_q, frame_start_q, animate_q, screenend_q;

  // next raster position: advance one pixel per enabled strobe, wrapping line then frame
  always_comb begin
    adv = bus.i_pix_stb & bus.i_en;
    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // counters and every output registered together from the next position, so levels always describe h/v
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hs_q          <= ~H_SYNC_POL;
      vs_q          <= ~V_SYNC_POL;
      active_q      <= 1'b1;
      blank_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      animate_q     <= 1'b0;
      screenend_q   <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= (h_d >= H_SYNC_BEG && h_d < H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_q          <= (v_d >= V_SYNC_BEG && v_d < V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
      active_q      <= (h_d < H_ACT_N) && (v_d < V_ACT_N);
      blank_q       <= !((h_d < H_ACT_N) && (v_d < V_ACT_N));
      x_q           <= (h_d < H_ACT_N) ? h_d : H_ACT_LAST;
      y_q           <= (v_d < V_ACT_N) ? v_d : V_ACT_LAST;
      // pulses only on an advancing edge, so they clear on the following cycle regardless of strobe
      line_start_q  <= adv && (h_d == '0);
      frame_start_q <= adv && (h_d == '0) && (v_d == '0);
      animate_q     <= adv && (h_d == H_LAST) && (v_d == V_ACT_LAST);
      screenend_q   <= adv && (h_d == H_LAST) && (v_d == V_LAST);
    end
  end

  assign bus.o_hs          = hs_q;
  assign bus.o_vs          = vs_q;
  assign bus.o_active      = active_q;
  assign bus.o_blanking    = blank_q;
  assign bus.o_x           = x_q;
  assign bus.o_y           = y_q;
  assign bus.o_line_start  = line_start_q;
  assign bus.o_frame_start = frame_start_q;
  assign bus.o_animate     = animate_q;
  assign bus.o_screenend   = screenend_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_q;

  // frame count steps on the same edge that raises o_frame_start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_q <= '0;
    end else if (adv && (h_d == '0) && (v_d == '0)) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  assign bus.o_frame = frame_q;
`else
  assign bus.o_frame = {FRAME_W{1'b0}};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen in an 8x6 small mode
module tb_vga_timing_gen;

  localparam int HCW = 3;
  localparam int VCW = 3;
  localparam int FW  = 2;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FCNT = 1'b1;
`else
  localparam bit FCNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_timing_gen_if #(.H_CW(HCW), .V_CW(VCW), .FRAME_W(FW)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .H_CW(HCW), .V_CW(VCW), .FRAME_W(FW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs, vs, act, blank, ls, fs, an, se;
    logic [2:0] x;
    logic [2:0] y;
    logic [1:0] fr;
  } obs_t;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_h, m_v, m_fr;
  int   cyc = 0;
  int   an_cnt, se_cnt, an_cyc, se_cyc, fs_cyc, hs_low, vs_low, act_cnt;
  int   ls_times[$];
  int   xs [8] = '{1, 2, 3, 3, 3, 3, 3, 0};

  function automatic obs_t dut_obs();
    obs_t a;
    a.hs = bus.o_hs;           a.vs = bus.o_vs;
    a.act = bus.o_active;      a.blank = bus.o_blanking;
    a.ls = bus.o_line_start;   a.fs = bus.o_frame_start;
    a.an = bus.o_animate;      a.se = bus.o_screenend;
    a.x = bus.o_x;             a.y = bus.o_y;
    a.fr = bus.o_frame;
    return a;
  endfunction

  function automatic obs_t rst_exp();
    obs_t r = '0;
    r.hs = 1'b1; r.vs = 1'b1; r.act = 1'b1;
    return r;
  endfunction

  function automatic obs_t level_exp(int h, int v, int fr);
    obs_t e = '0;
    e.act   = (h < 4) && (v < 3);
    e.blank = !e.act;
    e.hs    = !(h == 5 || h == 6);
    e.vs    = !(v == 4);
    e.x     = 3'((h > 3) ? 3 : h);
    e.y     = 3'((v > 2) ? 2 : v);
    e.fr    = 2'(fr);
    return e;
  endfunction

  // drive one cycle of stimulus (caller is away from the rising edge), push model result, compare after the edge
  task automatic step(input logic stb, input logic en);
    obs_t e, a;
    logic adv;
    bus.i_pix_stb = stb;
    bus.i_en      = en;
    adv = stb & en;
    if (adv) begin
      m_h++;
      if (m_h == 8) begin
        m_h = 0;
        m_v++;
        if (m_v == 6) m_v = 0;
      end
      if (FCNT && m_h == 0 && m_v == 0) m_fr = (m_fr + 1) % 4;
    end
    e = level_exp(m_h, m_v, m_fr);
    if (adv) begin
      e.ls = (m_h == 0);
      e.fs = (m_h == 0) && (m_v == 0);
      e.an = (m_h == 7) && (m_v == 2);
      e.se = (m_h == 7) && (m_v == 5);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    a = dut_obs();
    e = sb_q.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL scoreboard cyc=%0d model h=%0d v=%0d got=%h want=%h", cyc, m_h, m_v, a, e);
    end
    if (a.an) begin an_cnt++; an_cyc = cyc; end
    if (a.se) begin se_cnt++; se_cyc = cyc; end
    if (a.fs) fs_cyc = cyc;
    if (a.ls) ls_times.push_back(cyc);
    if (!a.hs) hs_low++;
    if (!a.vs) vs_low++;
    if (a.act) act_cnt++;
  endtask

  task automatic clear_stats();
    an_cnt = 0; se_cnt = 0; an_cyc = -1; se_cyc = -1; fs_cyc = -1;
    hs_low = 0; vs_low = 0; act_cnt = 0; cyc = 0;
    ls_times.delete();
  endtask

  task automatic do_reset();
    obs_t a;
    @(negedge clk);
    rst = 1'b1;
    bus.i_pix_stb = 1'b0;
    bus.i_en      = 1'b0;
    #1;
    a = dut_obs();
    total++;
    if (a !== rst_exp()) begin
      bad++;
      $display("FAIL reset_assert got=%h want=%h", a, rst_exp());
    end
    @(negedge clk);
    rst = 1'b0;
    m_h = 0; m_v = 0; m_fr = 0;
    clear_stats();
  endtask

  task automatic test_reset();
    obs_t a;
    bus.i_pix_stb = 1'b0;
    bus.i_en      = 1'b0;
    rst = 1'b1;
    #22;
    a = dut_obs();
    total++;
    if (a !== rst_exp()) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", a, rst_exp());
    end
    @(negedge clk);
    rst = 1'b0;
    m_h = 0; m_v = 0; m_fr = 0;
    clear_stats();
    // no strobe: nothing moves and no frame_start on release
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
  endtask

  task automatic test_line();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1);
      total++;
      if (bus.o_x !== 3'(xs[k % 8])) begin
        bad++;
        $display("FAIL x_seq k=%0d got=%0d want=%0d", k, bus.o_x, xs[k % 8]);
      end
    end
    total++;
    if (hs_low !== 4) begin bad++; $display("FAIL hs_low got=%0d want=4", hs_low); end
    total++;
    if (act_cnt !== 8) begin bad++; $display("FAIL active_cnt got=%0d want=8", act_cnt); end
  endtask

  task automatic test_frame();
    do_reset();
    for (int k = 0; k < 48; k++) step(1'b1, 1'b1);
    total++;
    if (an_cnt !== 1 || an_cyc !== 23) begin
      bad++; $display("FAIL animate cnt=%0d cyc=%0d want 1 at 23", an_cnt, an_cyc);
    end
    total++;
    if (se_cnt !== 1 || se_cyc !== 47) begin
      bad++; $display("FAIL screenend cnt=%0d cyc=%0d want 1 at 47", se_cnt, se_cyc);
    end
    total++;
    if (fs_cyc !== 48) begin bad++; $display("FAIL frame_start cyc got=%0d want=48", fs_cyc); end
    total++;
    if (vs_low !== 8) begin bad++; $display("FAIL vs_low got=%0d want=8", vs_low); end
  endtask

  task automatic test_stb3();
    do_reset();
    for (int k = 0; k < 72; k++) step((k % 3) == 0, 1'b1);
    total++;
    if (ls_times.size() !== 3) begin
      bad++; $display("FAIL line_starts got=%0d want=3", ls_times.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (ls_times[i] - ls_times[i-1] !== 24) begin
          bad++; $display("FAIL line_period got=%0d want=24", ls_times[i] - ls_times[i-1]);
        end
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    total++;
    if (bus.o_x !== 3'd2 || bus.o_y !== 3'd1) begin
      bad++; $display("FAIL frozen x=%0d y=%0d want 2,1", bus.o_x, bus.o_y);
    end
    step(1'b1, 1'b1);
    total++;
    if (bus.o_x !== 3'd3) begin bad++; $display("FAIL resume x got=%0d want=3", bus.o_x); end
  endtask

  task automatic test_async_reset();
    obs_t a;
    do_reset();
    for (int k = 0; k < 38; k++) step(1'b1, 1'b1);
    total++;
    if (bus.o_vs !== 1'b0) begin bad++; $display("FAIL pre_reset vs got=%b want=0", bus.o_vs); end
    #2;
    rst = 1'b1;
    bus.i_pix_stb = 1'b0;
    bus.i_en      = 1'b0;
    #1;
    a = dut_obs();
    total++;
    if (a !== rst_exp()) begin bad++; $display("FAIL async_reset got=%h want=%h", a, rst_exp()); end
    @(negedge clk);
    rst = 1'b0;
    m_h = 0; m_v = 0; m_fr = 0;
    total++;
    if (bus.o_x !== 3'd0 || bus.o_y !== 3'd0 || bus.o_vs !== 1'b1) begin
      bad++; $display("FAIL post_release x=%0d y=%0d vs=%b want 0,0,1", bus.o_x, bus.o_y, bus.o_vs);
    end
    step(1'b1, 1'b1);
  endtask

  task automatic test_frame_cnt();
    do_reset();
    for (int k = 0; k < 240; k++) step(1'b1, 1'b1);
    total++;
    if (bus.o_frame !== (FCNT ? 2'd1 : 2'd0)) begin
      bad++; $display("FAIL frame_cnt got=%0d want=%0d", bus.o_frame, FCNT ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_stb3();
    test_enable();
    test_async_reset();
    test_frame_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
